sine_lut_arbiter: RTL and testbench

//  Shares one registered-read sine LUT (1-clk read latency, WIDTH-bit data, ROM_WIDTH-bit

---
 rtl/sine_lut_arbiter.sv | 155 +++++++++++++++
 tb/tb_sine_lut_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_lut_arbiter.sv
// sine_lut_arbiter: round-robin sharing of one registered-read sine LUT between
// NUM_REQ phase requesters. Each granted lookup travels a two-stage tag pipeline
// that lines its requester id up with the LUT data. The tagged result is then
// queued in a show-ahead response FIFO that drains under valid/ready.
// Credit accounting bounds the number of lookups in flight, so the FIFO can
// never overflow.
module sine_lut_arbiter #(
  parameter int WIDTH     = 8,
  parameter int ROM_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ROM_WIDTH-1:0] req_phase,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [ROM_WIDTH-1:0]         lut_phase,
  input  logic [WIDTH-1:0]             lut_sine,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]             rsp_sine,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = $clog2(RSP_DEPTH + 1);

  // Arbitration and credit
  logic [IDW-1:0]       rr_ptr;
  logic                 grant_hit;
  logic [IDW-1:0]       grant_idx;
  logic [ROM_WIDTH-1:0] grant_phase;
  logic [CW:0]          outstanding;
  logic                 credit_ok;
  logic                 accept;

  // Tag pipeline aligned with the LUT read latency
  logic           s1_valid;
  logic [IDW-1:0] s1_id;
  logic           s2_valid;
  logic [IDW-1:0] s2_id;

  // Response FIFO
  logic [IDW-1:0]   mem_id   [RSP_DEPTH];
  logic [WIDTH-1:0] mem_sine [RSP_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_count;
  logic [IDW-1:0]   last_id;
  logic [WIDTH-1:0] last_sine;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Everything issued but not yet popped; a same-cycle pop is not credited.
  assign outstanding = {1'b0, fifo_count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
  assign credit_ok   = outstanding < (CW+1)'(RSP_DEPTH);

  // Round-robin search: first valid requester at or after the pointer wins.
  always_comb begin
    int cand;
    // NOTE: every variable written here gets a default first so no path can leave it unassigned and infer a latch.
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_hit && req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  // Ready is forced low while reset is asserted so nothing is accepted during reset.
  assign accept      = grant_hit & credit_ok & reset_n;
  assign grant_phase = req_phase[grant_idx*ROM_WIDTH +: ROM_WIDTH];

  // One-hot ready towards the winning requester.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Accept: launch the LUT address, tag stage 1, advance the round-robin pointer.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      lut_phase <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (accept) begin
        lut_phase <= grant_phase;
        s1_id     <= grant_idx;
        rr_ptr    <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign push      = s2_valid;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;

  // FIFO storage: written when stage 2 delivers LUT data.
  // NOTE: the storage array has no reset; fifo_count alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= s2_id;
      mem_sine[wr_ptr] <= lut_sine;
    end
  end

  // FIFO pointers and occupancy, plus the held copy of the last popped result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_id    <= '0;
      last_sine  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        last_id   <= mem_id[rd_ptr];
        last_sine <= mem_sine[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Show-ahead head, or the last popped value when the FIFO is empty.
  assign rsp_id   = rsp_valid ? mem_id[rd_ptr]   : last_id;
  assign rsp_sine = rsp_valid ? mem_sine[rd_ptr] : last_sine;

  assign busy = s1_valid | s2_valid | rsp_valid;

endmodule

// File: tb/tb_sine_lut_arbiter.sv
// Bench for sine_lut_arbiter. It runs a directed vector table first, then
// hand-written sequences. A randomized phase follows. Throughout, a
// transaction-level reference model is updated every cycle. The model holds a
// queue of accepted lookups, a round-robin pointer and a credit rule.
module tb_sine_lut_arbiter;

  localparam int WIDTH     = 8;
  localparam int ROM_WIDTH = 8;
  localparam int NUM_REQ   = 4;
  localparam int RSP_DEPTH = 4;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ROM_WIDTH-1:0] req_phase;
  logic [NUM_REQ-1:0]           req_ready;
  logic [ROM_WIDTH-1:0]         lut_phase;
  logic [WIDTH-1:0]             lut_sine;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [1:0]                   rsp_id;
  logic [WIDTH-1:0]             rsp_sine;
  logic                         busy;

  logic [7:0] ph [NUM_REQ];
  assign req_phase = {ph[3], ph[2], ph[1], ph[0]};

  sine_lut_arbiter #(
    .WIDTH(WIDTH), .ROM_WIDTH(ROM_WIDTH), .NUM_REQ(NUM_REQ), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_phase(req_phase),
    .req_ready(req_ready), .lut_phase(lut_phase), .lut_sine(lut_sine),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sine(rsp_sine), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared sine LUT stand-in: registered read, mem[p] = p ^ 8'hA5.
  logic [7:0] lut_q;
  always @(posedge clk) lut_q <= lut_phase ^ 8'hA5;
  assign lut_sine = lut_q;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] id;
    logic [7:0] sine;
    int         stamp;
  } exp_t;

  exp_t       sb[$];
  int         m_ptr;
  logic [7:0] m_lut;
  logic [1:0] m_last_id;
  logic [7:0] m_last_sine;
  int         cyc;
  int         n_acc;

  task automatic model_reset();
    sb.delete();
    m_ptr       = 0;
    m_lut       = '0;
    m_last_id   = '0;
    m_last_sine = '0;
  endtask

  // Sample at the falling edge, compare against the model, then advance the
  // model by the transfers that will happen at the next rising edge.
  task automatic cycle_begin();
    logic [NUM_REQ-1:0] exp_rdy;
    bit   found;
    bit   exp_rv;
    int   idx;
    int   g;
    exp_t e;
    @(negedge clk);
    exp_rdy = '0;
    found   = 1'b0;
    g       = 0;
    if (sb.size() < RSP_DEPTH) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found        = 1'b1;
          g            = idx;
          exp_rdy[idx] = 1'b1;
        end
      end
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("lut_phase", 32'(lut_phase), 32'(m_lut));
    check("busy", 32'(busy), 32'(sb.size() != 0));
    exp_rv = (sb.size() != 0) && (cyc >= sb[0].stamp + 3);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      check("rsp_sine", 32'(rsp_sine), 32'(sb[0].sine));
    end else begin
      check("rsp_id_hold", 32'(rsp_id), 32'(m_last_id));
      check("rsp_sine_hold", 32'(rsp_sine), 32'(m_last_sine));
    end
    if (exp_rv && rsp_ready) begin
      m_last_id   = sb[0].id;
      m_last_sine = sb[0].sine;
      void'(sb.pop_front());
    end
    if (found) begin
      e.id    = 2'(g);
      e.sine  = ph[g] ^ 8'hA5;
      e.stamp = cyc;
      sb.push_back(e);
      m_ptr = (g + 1) % NUM_REQ;
      m_lut = ph[g];
      n_acc++;
    end
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      cycle_begin();
      cycle_end();
    end
  endtask

  task automatic drain(input string name);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) run(1);
    cycle_begin();
    check(name, 32'(busy), 32'(0));
    cycle_end();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] valid;
    logic       rsp_ready;
    logic [3:0] exp_ready;
    logic       exp_rsp_valid;
    logic [1:0] exp_id;
    logic [7:0] exp_sine;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n0;
    int dut_acc;

    // Single lookup from req 2, then the pointer-fairness sequence (3, then 0 before 3).
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 8'hB5, 1'b1};
    tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hB5, 1'b0};
    tbl[5]  = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2'd2, 8'hB5, 1'b0};
    tbl[6]  = '{4'b1001, 1'b1, 4'b0001, 1'b0, 2'd2, 8'hB5, 1'b1};
    tbl[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b0, 2'd2, 8'hB5, 1'b1};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 8'hE5, 1'b1};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h85, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 8'hE5, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hE5, 1'b0};

    ph[0] = 8'h20; ph[1] = 8'h30; ph[2] = 8'h10; ph[3] = 8'h40;
    n_acc = 0;
    model_reset();

    // Reset state, with every requester asserting valid.
    reset_n   = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_lut_phase", 32'(lut_phase), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_rsp_sine", 32'(rsp_sine), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    req_valid = '0;
    reset_n   = 1'b1;
    cyc       = 0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid;
      rsp_ready = tbl[i].rsp_ready;
      cycle_begin();
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_rsp_valid));
      check($sformatf("tbl%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].exp_id));
      check($sformatf("tbl%0d_rsp_sine", i), 32'(rsp_sine), 32'(tbl[i].exp_sine));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      cycle_end();
    end

    // Round-robin with all requesters valid; the pointer starts at 0 here.
    req_valid = '1;
    rsp_ready = 1'b1;
    n0 = n_acc;
    for (int k = 0; k < 16; k++) begin
      cycle_begin();
      if (k < 8) check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1) << (k % 4));
      cycle_end();
    end
    check("rr_throughput", 32'(n_acc - n0), 32'(16));
    drain("rr_drain_busy");

    // Backpressure: credit allows exactly RSP_DEPTH accepts.
    req_valid = '1;
    rsp_ready = 1'b0;
    dut_acc   = 0;
    for (int k = 0; k < 8; k++) begin
      cycle_begin();
      if ((req_ready & req_valid) != '0) dut_acc++;
      cycle_end();
    end
    check("bp_accepts", 32'(dut_acc), 32'(RSP_DEPTH));
    cycle_begin();
    check("bp_ready_low", 32'(req_ready), 32'(0));
    check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
    cycle_end();
    rsp_ready = 1'b1;
    run(12);
    drain("bp_drain_busy");

    // Randomized traffic with periodic consumer stalls.
    for (int k = 0; k < 2000; k++) begin
      req_valid = 4'($urandom);
      for (int r = 0; r < NUM_REQ; r++) ph[r] = 8'($urandom);
      rsp_ready = (k % 50 < 8) ? 1'b0 : ($urandom_range(0, 3) != 0);
      run(1);
    end
    drain("rand_drain_busy");

    // Reset with three lookups in flight.
    ph[0] = 8'h01; ph[1] = 8'h02; ph[2] = 8'h03; ph[3] = 8'h04;
    req_valid = '1;
    rsp_ready = 1'b0;
    run(3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'(0));
    check("mid_rst_lut_phase", 32'(lut_phase), 32'(0));
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_rsp_id", 32'(rsp_id), 32'(0));
    check("mid_rst_rsp_sine", 32'(rsp_sine), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    cycle_begin();
    check("post_rst_first_grant", 32'(req_ready), 32'(1));
    check("post_rst_no_stale", 32'(rsp_valid), 32'(0));
    cycle_end();
    run(10);
    drain("post_rst_drain_busy");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
